// File: rtl/ip_hdr_assemble.sv
// rtl/ip_hdr_assemble.sv - builds a 20-byte IPv4 header with a sequentially summed checksum
module ip_hdr_assemble #(
  parameter logic [7:0]  TTL       = 8'd64,
  parameter logic        DONT_FRAG = 1'b1,
  parameter logic [15:0] ID_INIT   = 16'h0000,
  localparam int         IP_HDR_W     = 160,
  localparam int         IP_HDR_BYTES = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                src_ip_hdr_assemble_req_val,
  input  logic [31:0]         src_ip_hdr_assemble_src_ip,
  input  logic [31:0]         src_ip_hdr_assemble_dst_ip,
  input  logic [7:0]          src_ip_hdr_assemble_protocol,
  input  logic [15:0]         src_ip_hdr_assemble_payload_len,
  output logic                ip_hdr_assemble_src_req_rdy,
  output logic                ip_hdr_assemble_dst_hdr_val,
  output logic [IP_HDR_W-1:0] ip_hdr_assemble_dst_ip_hdr,
  input  logic                dst_ip_hdr_assemble_hdr_rdy
);

  typedef enum logic [1:0] {IDLE, SUM, FOLD, OUTPUT} state_e;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] tot_len;
    logic [15:0] id;
    logic [15:0] frag_offset;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] chksum;
    logic [31:0] source_addr;
    logic [31:0] dest_addr;
  } ip_pkt_hdr_t;

  state_e           state_q, state_d;
  ip_pkt_hdr_t      hdr_q, hdr_d;
  logic [19:0]      acc_q, acc_d;
  logic [3:0]       idx_q, idx_d;
  logic [15:0]      id_q, id_d;
  logic             hdr_val_q, hdr_val_d;
  logic [9:0][15:0] words;
  logic [16:0]      s1;
  logic [15:0]      s2;

  // Word 9 is the most significant 16 bits, so idx 0 walks the header from the top.
  assign words = hdr_q;
  assign s1    = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
  assign s2    = s1[15:0] + {15'd0, s1[16]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (src_ip_hdr_assemble_req_val) state_d = SUM;
      SUM:     if (idx_q == 4'd9) state_d = FOLD;
      FOLD:    state_d = OUTPUT;
      OUTPUT:  if (dst_ip_hdr_assemble_hdr_rdy) state_d = IDLE;
      default: state_d = state_e'('x);
    endcase
  end

  always_comb begin
    ip_hdr_assemble_src_req_rdy = 1'b0;
    case (state_q)
      IDLE:             ip_hdr_assemble_src_req_rdy = 1'b1;
      SUM, FOLD, OUTPUT: ip_hdr_assemble_src_req_rdy = 1'b0;
      default:          ip_hdr_assemble_src_req_rdy = 1'bx;
    endcase
  end

  always_comb begin
    hdr_d = hdr_q;
    acc_d = acc_q;
    idx_d = idx_q;
    id_d  = id_q;
    case (state_q)
      IDLE: begin
        if (src_ip_hdr_assemble_req_val) begin
          hdr_d.version     = 4'd4;
          hdr_d.ihl         = 4'd5;
          hdr_d.tos         = 8'd0;
          hdr_d.tot_len     = src_ip_hdr_assemble_payload_len + 16'(IP_HDR_BYTES);
          hdr_d.id          = id_q;
          hdr_d.frag_offset = {1'b0, DONT_FRAG, 14'd0};
          hdr_d.ttl         = TTL;
          hdr_d.protocol    = src_ip_hdr_assemble_protocol;
          hdr_d.chksum      = 16'd0;
          hdr_d.source_addr = src_ip_hdr_assemble_src_ip;
          hdr_d.dest_addr   = src_ip_hdr_assemble_dst_ip;
          acc_d             = 20'd0;
          idx_d             = 4'd0;
        end
      end
      SUM: begin
        acc_d = acc_q + {4'd0, words[4'd9 - idx_q]};
        idx_d = idx_q + 4'd1;
      end
      FOLD: begin
        hdr_d.chksum = ~s2;
      end
      OUTPUT: begin
        if (dst_ip_hdr_assemble_hdr_rdy) id_d = id_q + 16'd1;
      end
      default: begin
        hdr_d = 'x;
        acc_d = 'x;
        idx_d = 'x;
        id_d  = 'x;
      end
    endcase
  end

  assign hdr_val_d = (state_d == OUTPUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      id_q      <= ID_INIT;
      hdr_val_q <= 1'b0;
    end else begin
      hdr_q     <= hdr_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      id_q      <= id_d;
      hdr_val_q <= hdr_val_d;
    end
  end

  assign ip_hdr_assemble_dst_hdr_val = hdr_val_q;
  assign ip_hdr_assemble_dst_ip_hdr  = hdr_q;

endmodule

// File: tb/tb_ip_hdr_assemble.sv
// tb/tb_ip_hdr_assemble.sv - self-checking bench for ip_hdr_assemble
module tb_ip_hdr_assemble;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_val, req_val2;
  logic [31:0]  src_ip, dst_ip;
  logic [7:0]   proto;
  logic [15:0]  plen;
  logic         req_rdy, req_rdy2;
  logic         hdr_val, hdr_val2;
  logic [159:0] ip_hdr, ip_hdr2;
  logic         hdr_rdy;
  logic         hdr_rdy2 = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [15:0]  id_model = 16'h0000;
  logic [159:0] exp_q[$];

  ip_hdr_assemble dut (
    .clk                             (clk),
    .rst                             (rst),
    .src_ip_hdr_assemble_req_val     (req_val),
    .src_ip_hdr_assemble_src_ip      (src_ip),
    .src_ip_hdr_assemble_dst_ip      (dst_ip),
    .src_ip_hdr_assemble_protocol    (proto),
    .src_ip_hdr_assemble_payload_len (plen),
    .ip_hdr_assemble_src_req_rdy     (req_rdy),
    .ip_hdr_assemble_dst_hdr_val     (hdr_val),
    .ip_hdr_assemble_dst_ip_hdr      (ip_hdr),
    .dst_ip_hdr_assemble_hdr_rdy     (hdr_rdy)
  );

  // Second instance starts its id counter at 0xFFFF to reach the wrap quickly.
  ip_hdr_assemble #(.ID_INIT(16'hFFFF)) dut2 (
    .clk                             (clk),
    .rst                             (rst),
    .src_ip_hdr_assemble_req_val     (req_val2),
    .src_ip_hdr_assemble_src_ip      (src_ip),
    .src_ip_hdr_assemble_dst_ip      (dst_ip),
    .src_ip_hdr_assemble_protocol    (proto),
    .src_ip_hdr_assemble_payload_len (plen),
    .ip_hdr_assemble_src_req_rdy     (req_rdy2),
    .ip_hdr_assemble_dst_hdr_val     (hdr_val2),
    .ip_hdr_assemble_dst_ip_hdr      (ip_hdr2),
    .dst_ip_hdr_assemble_hdr_rdy     (hdr_rdy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [159:0] model(input logic [15:0] id, input logic [31:0] s,
                                         input logic [31:0] d, input logic [7:0] p,
                                         input logic [15:0] len);
    logic [159:0] h;
    logic [31:0]  sum;
    logic [15:0]  tl;
    tl  = len + 16'd20;
    h   = {4'h4, 4'h5, 8'h00, tl, id, 16'h4000, 8'd64, p, 16'h0000, s, d};
    sum = 0;
    for (int i = 0; i < 10; i++) sum += {16'd0, h[159-16*i -: 16]};
    while ((sum >> 16) != 0) sum = (sum & 32'h0000FFFF) + (sum >> 16);
    h[79:64] = ~sum[15:0];
    return h;
  endfunction

  always @(negedge clk) begin
    if (!rst && hdr_val && hdr_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got header %h expected none", ip_hdr);
      end else begin
        chk("sb_hdr", ip_hdr, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] s, input logic [31:0] d, input logic [7:0] p,
                      input logic [15:0] len, input bit push, output int acc_cyc);
    int g = 0;
    @(negedge clk);
    req_val = 1'b1; src_ip = s; dst_ip = d; proto = p; plen = len;
    while (!req_rdy && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("req_rdy_timeout", 160'(req_rdy), 160'd1);
    @(posedge clk);
    acc_cyc = cyc;
    if (push) begin
      exp_q.push_back(model(id_model, s, d, p, len));
      id_model++;
    end
    #1 req_val = 1'b0;
  endtask

  task automatic wait_val(output int lat);
    lat = 0;
    while (!hdr_val && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic drain();
    int g = 0;
    while (hdr_val && g < 40) begin
      @(posedge clk);
      #1 g++;
    end
    if (g >= 40) chk("drain_timeout", 160'(hdr_val), 160'd0);
  endtask

  typedef struct {
    logic [31:0] s;
    logic [31:0] d;
    logic [7:0]  p;
    logic [15:0] len;
    logic [15:0] tot;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int lat, a1, a2, g;
    logic [159:0] snap;

    vecs[0] = '{32'h0A000001, 32'h0A0000FE, 8'h06, 16'd0,     16'h0014};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 16'd65515, 16'hFFFF};
    vecs[2] = '{32'h7F000001, 32'h08080808, 8'h01, 16'd65516, 16'h0000};
    vecs[3] = '{32'h00000000, 32'h00000000, 8'h00, 16'd1480,  16'h05DC};
    vecs[4] = '{32'hAC10FE01, 32'hC0000201, 8'h11, 16'd512,   16'h0214};

    rst = 1'b1; req_val = 1'b0; req_val2 = 1'b0; hdr_rdy = 1'b1;
    src_ip = '0; dst_ip = '0; proto = '0; plen = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hdr_val", 160'(hdr_val), 160'd0);
    chk("rst_ip_hdr", ip_hdr, 160'd0);
    chk("rst_req_rdy", 160'(req_rdy), 160'd1);

    send(32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd95, 1'b1, a1);
    wait_val(lat);
    chk("first_latency", 160'(lat), 160'd11);
    chk("first_hdr", ip_hdr, 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7);
    chk("output_req_rdy", 160'(req_rdy), 160'd0);
    send(32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd95, 1'b1, a2);
    chk("accept_interval", 160'(a2 - a1), 160'd13);
    wait_val(lat);
    chk("second_id", 160'(ip_hdr[127:112]), 160'h0001);
    chk("second_chksum", 160'(ip_hdr[79:64]), 160'hB860);
    drain();

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].s, vecs[i].d, vecs[i].p, vecs[i].len, 1'b1, a1);
      wait_val(lat);
      chk("vec_latency", 160'(lat), 160'd11);
      chk("vec_tot_len", 160'(ip_hdr[143:128]), 160'(vecs[i].tot));
      drain();
    end

    hdr_rdy = 1'b0;
    send(32'h01020304, 32'h05060708, 8'h06, 16'd40, 1'b1, a1);
    wait_val(lat);
    snap = ip_hdr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_stable", ip_hdr, snap);
      chk("stall_req_rdy", 160'(req_rdy), 160'd0);
      chk("stall_hdr_val", 160'(hdr_val), 160'd1);
    end
    @(posedge clk);
    #1 hdr_rdy = 1'b1;
    drain();
    send(32'h01020304, 32'h05060708, 8'h06, 16'd40, 1'b1, a1);
    wait_val(lat);
    chk("stall_next_id", 160'(ip_hdr[127:112]), 160'(id_model - 16'd1));
    drain();

    send(32'hDEADBEEF, 32'hCAFEF00D, 8'h11, 16'd100, 1'b0, a1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_hdr_val", 160'(hdr_val), 160'd0);
    chk("midrst_req_rdy", 160'(req_rdy), 160'd1);
    chk("midrst_ip_hdr", ip_hdr, 160'd0);
    id_model = 16'h0000;
    send(32'hDEADBEEF, 32'hCAFEF00D, 8'h11, 16'd100, 1'b1, a1);
    wait_val(lat);
    chk("midrst_id", 160'(ip_hdr[127:112]), 160'h0000);
    drain();

    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      src_ip = 32'hC0A80001; dst_ip = 32'hC0A800C7; proto = 8'h11; plen = 16'd95;
      req_val2 = 1'b1;
      @(posedge clk);
      #1 req_val2 = 1'b0;
      g = 0;
      while (!hdr_val2 && g < 40) begin
        @(posedge clk);
        #1 g++;
      end
      chk(k == 0 ? "wrap_hdr_ffff" : "wrap_hdr_0000", ip_hdr2,
          model(k == 0 ? 16'hFFFF : 16'h0000, 32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd95));
      @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", 160'(exp_q.size()), 160'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
